// File: rtl/press_pkg.sv
// press_pkg: shared state encoding and default timing for the push-button front end.
package press_pkg;
  typedef enum logic [2:0] {IDLE, DEB_P, HELD, LONG, DEB_R} press_state_e;
  localparam int DEB_MS_DEF    = 20;
  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;
endpackage

// File: rtl/press_chan.sv
// press_chan: one button channel -- synchroniser, debounce/hold FSM and registered pulses.
module press_chan
  import press_pkg::*;
#(
  parameter int DEB_MS    = DEB_MS_DEF,
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = 11
) (
  input  logic clk_ms,
  input  logic rst_on,
  input  logic btn_i,
  input  logic rpt_en_i,
  output logic short_o,
  output logic long_o,
  output logic repeat_o,
  output logic long_level_o,
  output logic long_ev_o
);
  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEB_MS - 1);
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] RPT_END  = CNT_W'(REPEAT_MS - 1);
  press_state_e     state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] tmr_q, hcnt_q;
  logic             was_long_q;
  logic             s;
  assign s            = sync_q[1];
  assign long_ev_o    = (state_q == HELD) && s && (hcnt_q == LONG_END);
  assign long_level_o = (state_q == LONG);
  always_ff @(posedge clk_ms or negedge rst_on) begin
    if (!rst_on) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      tmr_q      <= '0;
      hcnt_q     <= '0;
      was_long_q <= 1'b0;
      short_o    <= 1'b0;
      long_o     <= 1'b0;
      repeat_o   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      repeat_o <= 1'b0;
      case (state_q)
        IDLE: if (s) begin
          state_q <= DEB_P;
          tmr_q   <= '0;
        end
        DEB_P: if (!s) state_q <= IDLE;
        else if (tmr_q == DEB_END) begin
          state_q    <= HELD;
          hcnt_q     <= '0;
          was_long_q <= 1'b0;
        end else tmr_q <= tmr_q + 1'b1;
        HELD: if (!s) begin
          state_q <= DEB_R;
          tmr_q   <= '0;
        end else if (long_ev_o) begin
          state_q    <= LONG;
          was_long_q <= 1'b1;
          long_o     <= 1'b1;
          hcnt_q     <= '0;
        end else hcnt_q <= hcnt_q + 1'b1;
        LONG: if (!s) begin
          state_q <= DEB_R;
          tmr_q   <= '0;
        end else if (rpt_en_i && hcnt_q == RPT_END) begin
          repeat_o <= 1'b1;
          hcnt_q   <= '0;
        end else hcnt_q <= rpt_en_i ? hcnt_q + 1'b1 : '0;
        // hcnt is preserved across a release glitch so the hold is not restarted
        DEB_R: if (s) state_q <= was_long_q ? LONG : HELD;
        else if (tmr_q == DEB_END) begin
          state_q <= IDLE;
          short_o <= !was_long_q;
        end else tmr_q <= tmr_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/press_multi_ctrl.sv
// press_multi_ctrl: NCH independent button channels plus a power latch toggled
// by each long press of channel PWR_CH.
module press_multi_ctrl
  import press_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DEB_MS    = DEB_MS_DEF,
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int PWR_CH    = 0,
  parameter int CNT_W     = 11
) (
  input  logic           clk_ms,
  input  logic           rst_on,
  input  logic [NCH-1:0] btn_in,
  input  logic [NCH-1:0] rpt_en,
  output logic [NCH-1:0] short_pulse,
  output logic [NCH-1:0] long_pulse,
  output logic [NCH-1:0] long_level,
  output logic [NCH-1:0] repeat_pulse,
  output logic           pwr_on
);
  logic [NCH-1:0] long_ev;
  logic           pwr_on_q;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    press_chan #(
      .DEB_MS(DEB_MS), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS), .CNT_W(CNT_W)
    ) u_chan (
      .clk_ms(clk_ms), .rst_on(rst_on), .btn_i(btn_in[i]), .rpt_en_i(rpt_en[i]),
      .short_o(short_pulse[i]), .long_o(long_pulse[i]), .repeat_o(repeat_pulse[i]),
      .long_level_o(long_level[i]), .long_ev_o(long_ev[i])
    );
  end
  // Toggle on the edge that registers long_pulse, so the latch moves with the pulse
  always_ff @(posedge clk_ms or negedge rst_on) begin
    if (!rst_on) pwr_on_q <= 1'b0;
    else if (long_ev[PWR_CH]) pwr_on_q <= !pwr_on_q;
  end
  assign pwr_on = pwr_on_q;
endmodule

// File: tb/tb_press_multi_ctrl.sv
// tb_press_multi_ctrl: directed vector table plus hand sequences for timing, glitches and reset.
module tb_press_multi_ctrl;
  logic       clk_ms = 1'b0;
  logic       rst_on = 1'b0;
  logic [3:0] btn_in = '0;
  logic [3:0] rpt_en = '0;
  logic [3:0] short_pulse, long_pulse, long_level, repeat_pulse;
  logic       pwr_on;

  press_multi_ctrl dut (
    .clk_ms(clk_ms), .rst_on(rst_on), .btn_in(btn_in), .rpt_en(rpt_en),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .long_level(long_level),
    .repeat_pulse(repeat_pulse), .pwr_on(pwr_on)
  );

  always #5 clk_ms = ~clk_ms;

  typedef struct {
    int ch; int len; int rpt;
    int es; int el; int er; int ep; int elvl;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int sc[4], lc[4], rc[4];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 4; c++) begin sc[c] = 0; lc[c] = 0; rc[c] = 0; end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_ms);
      for (int c = 0; c < 4; c++) begin
        sc[c] += int'(short_pulse[c]);
        lc[c] += int'(long_pulse[c]);
        rc[c] += int'(repeat_pulse[c]);
      end
    end
  endtask

  vec_t v[7];

  initial begin
    int first_l, first_r, pwr_before, pwr_at;
    v[0] = '{1,  100, 0, 1, 0, 0, 0, 0};
    v[1] = '{0, 1500, 0, 0, 1, 0, 1, 1};
    v[2] = '{2, 1500, 1, 0, 1, 2, 1, 1};
    v[3] = '{3,   10, 0, 0, 0, 0, 1, 0};
    v[4] = '{3,   19, 0, 0, 0, 0, 1, 0};
    v[5] = '{0, 1500, 1, 0, 1, 2, 0, 1};
    v[6] = '{1, 1100, 1, 0, 1, 0, 0, 1};

    step(3);
    chk("reset_outputs", int'({short_pulse, long_pulse, long_level, repeat_pulse}), 0);
    chk("reset_pwr", int'(pwr_on), 0);
    rst_on = 1'b1;
    step(5);

    for (int i = 0; i < 7; i++) begin
      clr();
      rpt_en = '0;
      rpt_en[v[i].ch] = v[i].rpt[0];
      btn_in[v[i].ch] = 1'b1;
      step(v[i].len);
      chk($sformatf("vec%0d_level_held", i), int'(long_level[v[i].ch]), v[i].elvl);
      btn_in[v[i].ch] = 1'b0;
      step(60);
      chk($sformatf("vec%0d_short", i), sc[v[i].ch], v[i].es);
      chk($sformatf("vec%0d_long", i), lc[v[i].ch], v[i].el);
      chk($sformatf("vec%0d_repeat", i), rc[v[i].ch], v[i].er);
      chk($sformatf("vec%0d_pwr", i), int'(pwr_on), v[i].ep);
      chk($sformatf("vec%0d_level_rel", i), int'(long_level[v[i].ch]), 0);
    end

    // Exact latency of long_pulse, pwr_on toggle edge and first repeat
    clr();
    rpt_en = 4'b0001;
    first_l = -1; first_r = -1; pwr_before = -1; pwr_at = -1;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 1250; k++) begin
      if (k == 1022) pwr_before = int'(pwr_on);
      step(1);
      if (long_pulse[0] && first_l < 0) begin first_l = k; pwr_at = int'(pwr_on); end
      if (repeat_pulse[0] && first_r < 0) first_r = k;
    end
    chk("long_latency", first_l, 1023);
    chk("pwr_before_long", pwr_before, 0);
    chk("pwr_at_long", pwr_at, 1);
    chk("repeat_latency", first_r, 1223);
    btn_in[0] = 1'b0;
    step(60);
    chk("timing_long_count", lc[0], 1);
    chk("timing_short_count", sc[0], 0);

    // Release glitches in HELD and in LONG on ch3
    clr();
    rpt_en = '0;
    btn_in[3] = 1'b1; step(500);
    btn_in[3] = 1'b0; step(5);
    btn_in[3] = 1'b1; step(600);
    btn_in[3] = 1'b0; step(5);
    btn_in[3] = 1'b1; step(50);
    chk("glitch_level_back", int'(long_level[3]), 1);
    chk("glitch_long_once", lc[3], 1);
    btn_in[3] = 1'b0; step(60);
    chk("glitch_long_total", lc[3], 1);
    chk("glitch_short", sc[3], 0);
    chk("glitch_repeat", rc[3], 0);
    chk("glitch_pwr", int'(pwr_on), 1);

    // Reset mid-hold, then the still-held button acts as a fresh press
    rpt_en = 4'b0100;
    btn_in[2] = 1'b1;
    step(1100);
    chk("pre_reset_level", int'(long_level[2]), 1);
    #2 rst_on = 1'b0;
    #1;
    chk("async_reset_outputs", int'({short_pulse, long_pulse, long_level, repeat_pulse}), 0);
    chk("async_reset_pwr", int'(pwr_on), 0);
    @(negedge clk_ms);
    rst_on = 1'b1;
    clr();
    step(800);
    chk("post_reset_quiet", lc[2] + rc[2] + sc[2], 0);
    chk("post_reset_level", int'(long_level[2]), 0);
    step(400);
    chk("post_reset_long", lc[2], 1);
    chk("post_reset_repeat", rc[2], 0);
    chk("post_reset_level_long", int'(long_level[2]), 1);
    chk("post_reset_pwr", int'(pwr_on), 0);
    btn_in = '0;
    step(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/press_multi_ctrl.md
Name: press_multi_ctrl

Overview:
- Multi-channel push-button front end for the car control board: synchronise, debounce and classify each button press as short, long or held-repeat.
- Also keeps a power latch that toggles on each long press of a chosen channel.
- Runs on the 1 kHz clk_ms tick clock, so one cycle is 1 ms.
- Feeds the mode and driving-control logic in place of per-button ad-hoc counters.

Parameters:
- NCH, 4: number of button channels.
- DEB_MS, 20: debounce window in cycles; must be ≥1.
- LONG_MS, 1000: hold time that qualifies a long press; must be ≥1.
- REPEAT_MS, 200: auto-repeat period while held past long; must be ≥1.
- PWR_CH, 0: channel whose long press toggles pwr_on.
- CNT_W, 11: counter width; must hold max(DEB_MS, LONG_MS, REPEAT_MS)-1.

Ports:
- clk_ms  in  1  1 kHz clock, rising edge.
- rst_on  in  1  reset, asynchronous, active-low.
- btn_in  in  NCH  raw buttons, asynchronous, active-high.
- rpt_en  in  NCH  per-channel auto-repeat enable.
- short_pulse  out  NCH  1-cycle pulse: released before LONG_MS.
- long_pulse  out  NCH  1-cycle pulse: hold reached LONG_MS.
- long_level  out  NCH  high while channel is in LONG.
- repeat_pulse  out  NCH  1-cycle pulse every REPEAT_MS in LONG when rpt_en.
- pwr_on  out  1  power latch.

Behaviour:
- Reset (rst_on=0, asynchronous):
  - all FSMs go to IDLE; counters and sync flops clear.
  - all outputs are 0, including pwr_on.
- Each channel has an independent 2-flop synchroniser; s = second flop.
- Per channel: debounce timer tmr and hold counter hcnt, both CNT_W bits. Flag was_long records whether LONG was reached.
- FSM per channel, evaluated each edge:
  - IDLE: s=1 → DEB_P, tmr=0.
  - DEB_P: s=0 → IDLE, no output. s=1 and tmr==DEB_MS-1 → HELD, hcnt=0, was_long=0. Otherwise tmr++.
  - HELD: s=0 → DEB_R, tmr=0. hcnt==LONG_MS-1 → LONG, was_long=1, long_pulse=1 for the next cycle, hcnt=0. Otherwise hcnt++.
  - LONG: s=0 → DEB_R, tmr=0. rpt_en=1 and hcnt==REPEAT_MS-1 → repeat_pulse=1, hcnt=0. rpt_en=1 otherwise → hcnt++. rpt_en=0 → hcnt holds at 0.
  - DEB_R:
    - s=1 → return to LONG if was_long, else HELD. hcnt is kept; a release glitch does not restart the hold.
    - s=0 and tmr==DEB_MS-1 → IDLE, with short_pulse=1 for the next cycle if was_long=0.
    - otherwise tmr++.
- long_level = (state==LONG). It drops on entry to DEB_R and comes back if the FSM returns to LONG.
- All outputs are registered; pulses are exactly 1 cycle.
- Latency: btn_in high before edge 1 →
  - DEB_P at edge 3;
  - HELD at edge 3+DEB_MS;
  - long_pulse high after edge 3+DEB_MS+LONG_MS;
  - first repeat_pulse after a further REPEAT_MS edges.
- short_pulse and long_pulse are mutually exclusive per press. A press shorter than DEB_MS produces no output.
- pwr_on toggles on the same edge that registers long_pulse[PWR_CH]=1. It toggles exactly once per long press; repeat has no effect on it.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- rpt_en changing mid-LONG takes effect on the next edge. It does not emit a spurious pulse.
- Reset mid-press: on release of reset, a still-pressed button is treated as a fresh press from IDLE.

Decomposition:
- Shared package press_pkg holds:
  - state encoding (IDLE, DEB_P, HELD, LONG, DEB_R);
  - default timing constants DEB_MS_DEF, LONG_MS_DEF, REPEAT_MS_DEF.
- One sub-module press_chan covers a single channel: synchroniser, FSM, counters, per-channel outputs.
- Top press_multi_ctrl instantiates NCH copies with a generate loop and owns the pwr_on latch.

Test Plan (DEB_MS=20, LONG_MS=1000, REPEAT_MS=200, NCH=4):
- Ch1 high for 100 cycles, then low → exactly one short_pulse[1], no long_pulse, pwr_on stays 0.
- Ch0 held 1500 cycles, rpt_en=0:
  - long_pulse[0] once, after edge 1023;
  - pwr_on 0→1 on that edge;
  - long_level[0] high until release;
  - no short_pulse.
- Ch2 held 1500 cycles, rpt_en=1 → long_pulse once, then repeat_pulse at 200-cycle spacing: 2 pulses before release.
- Ch3 high for 10 cycles (bounce < DEB_MS), and a 5-cycle low glitch during a long hold → no pulses from the short burst; the glitch does not re-fire long_pulse.
- Second long press on ch0 → pwr_on 1→0. rst_on low mid-hold → all outputs 0 immediately, no pulses until a fresh press.
